sub8_approx_pipe: RTL and testbench

- Pipelined 8-bit approximate subtractor, the inverse-operation companion to the library's approximate 8-bit adders.
- Computes O = A - B as a 9-bit two's-complement result, using the same LSB approximation style: bit 0 is computed locally and no carry or borrow leaves bit 0.
- Sits in the approximate-arithmetic datapath between operand producers and consumers, with valid/ready handshakes on both sides.
- Worst-case error 1, error probability 25 % when approximation is enabled.

---
 rtl/sub8_approx_pkg.sv | 22 ++
 rtl/sub8_pipe_stage.sv | 34 +++
 rtl/sub8_approx_pipe.sv | 129 ++++++++++++
 tb/tb_sub8_approx_pipe.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sub8_approx_pkg.sv
// Shared widths, types and the bit-0 helper for the pipelined approximate subtractor.
package sub8_approx_pkg;

  localparam int OP_W  = 8;
  localparam int RES_W = 9;

  typedef logic signed [RES_W-1:0] res_t;

  // Stage-1 payload: only the operand bits still needed by stage 2 are kept.
  typedef struct packed {
    logic [2:0] a_top;
    logic [2:0] b_top;
    logic [3:0] lo;
    logic       br;
    logic       d0;
  } s1_t;

  function automatic logic approx_lsb_sub(input logic a0, input logic b0);
    return a0 & ~b0;
  endfunction

endpackage

// File: rtl/sub8_pipe_stage.sv
// Generic valid/ready register slice; advances whenever it is empty or downstream accepts.
module sub8_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q;
  logic [W-1:0] data_q;
  logic         advance;

  assign advance   = ~valid_q | out_ready;
  assign in_ready  = advance;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (advance) begin
      valid_q <= in_valid;
      if (in_valid) data_q <= in_data;
    end
  end

endmodule

// File: rtl/sub8_approx_pipe.sv
// Two-stage 8-bit subtractor O = A - B (9-bit two's complement), bit 0 optionally borrow-free.
// Define SUB8_APPROX_ERRSTAT_EN to carry an exact difference and count ops/mismatches.
module sub8_approx_pipe
  import sub8_approx_pkg::*;
#(
  parameter int APPROX_LSB = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  A,
  input  logic [OP_W-1:0]  B,
  output logic             out_valid,
  input  logic             out_ready,
  output res_t             O,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] op_cnt
);

`ifdef SUB8_APPROX_ERRSTAT_EN
  localparam int S1_W = $bits(s1_t) + RES_W;
  localparam int S2_W = 2 * RES_W;
`else
  localparam int S1_W = $bits(s1_t);
  localparam int S2_W = RES_W;
`endif

  logic       d0;
  logic       bw0;
  logic [4:0] low5;
  logic [3:0] hi4;
  s1_t        s1_in;
  s1_t        s1_out;
  res_t       s2_in;
  logic       s1_valid;
  logic       s2_in_ready;
  logic [S1_W-1:0] s1_d;
  logic [S1_W-1:0] s1_q;
  logic [S2_W-1:0] s2_d;
  logic [S2_W-1:0] s2_q;

  // Bit 0 and the borrow it feeds into bits 1..4; the approximate form never borrows.
  generate
    if (APPROX_LSB != 0) begin : g_apx_lsb
      assign d0  = approx_lsb_sub(A[0], B[0]);
      assign bw0 = 1'b0;
    end else begin : g_exact_lsb
      assign d0  = A[0] ^ B[0];
      assign bw0 = ~A[0] & B[0];
    end
  endgenerate

  assign low5  = {1'b0, A[4:1]} - {1'b0, B[4:1]} - {4'b0000, bw0};
  assign s1_in = '{a_top: A[7:5], b_top: B[7:5], lo: low5[3:0], br: low5[4], d0: d0};

  // Upper nibble plus sign: 4-bit wraparound yields the correct 9-bit two's complement.
  assign hi4   = {1'b0, s1_out.a_top} - {1'b0, s1_out.b_top} - {3'b000, s1_out.br};
  assign s2_in = {hi4, s1_out.lo, s1_out.d0};

`ifdef SUB8_APPROX_ERRSTAT_EN
  res_t ex_in;
  res_t ex_s1;
  res_t ex_s2;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
  logic             out_xfer;

  assign ex_in           = {1'b0, A} - {1'b0, B};
  assign s1_d            = {ex_in, s1_in};
  assign {ex_s1, s1_out} = s1_q;
  assign s2_d            = {ex_s1, s2_in};
  assign {ex_s2, O}      = s2_q;
  assign out_xfer        = out_valid & out_ready;

  always_comb begin
    op_cnt_d  = op_cnt_q;
    err_cnt_d = err_cnt_q;
    if (out_xfer) begin
      if (op_cnt_q != '1) op_cnt_d = op_cnt_q + CNT_W'(1);
      if ((O != ex_s2) && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      op_cnt_q  <= op_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign op_cnt  = op_cnt_q;
  assign err_cnt = err_cnt_q;
`else
  assign s1_d    = s1_in;
  assign s1_out  = s1_q;
  assign s2_d    = s2_in;
  assign O       = s2_q;
  assign op_cnt  = '0;
  assign err_cnt = '0;
`endif

  sub8_pipe_stage #(.W(S1_W)) u_stage1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_d),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_q)
  );

  sub8_pipe_stage #(.W(S2_W)) u_stage2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (s2_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_q)
  );

endmodule

// File: tb/tb_sub8_approx_pipe.sv
// Bench for sub8_approx_pipe: an approximate and an exact instance share stimulus and are
// checked every cycle against an arithmetic model; honours SUB8_APPROX_ERRSTAT_EN.
module tb_sub8_approx_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] A = 8'h00;
  logic [7:0] B = 8'h00;

  logic        in_ready_a, out_valid_a, in_ready_e, out_valid_e;
  logic [8:0]  O_a, O_e;
  logic [16:0] err_a, op_a;
  logic [15:0] err_e, op_e;

  always #5 clk = ~clk;

  sub8_approx_pipe #(.APPROX_LSB(1), .CNT_W(17)) u_apx (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .A(A), .B(B), .out_valid(out_valid_a), .out_ready(out_ready), .O(O_a),
    .err_cnt(err_a), .op_cnt(op_a)
  );

  sub8_approx_pipe #(.APPROX_LSB(0), .CNT_W(16)) u_exact (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_e),
    .A(A), .B(B), .out_valid(out_valid_e), .out_ready(out_ready), .O(O_e),
    .err_cnt(err_e), .op_cnt(op_e)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
  } pair_t;
  pair_t q[$];

  longint m_op_a = 0, m_err_a = 0, m_op_e = 0;
  logic       hold_v = 1'b0;
  logic [8:0] hold_o = '0;

  // Approximate result: twice the difference of the upper 7 bits plus the borrow-free bit 0.
  function automatic logic [8:0] ref_apx(input logic [7:0] a, input logic [7:0] b);
    int u;
    u = int'(a >> 1) - int'(b >> 1);
    return 9'(2 * u + ((a[0] && !b[0]) ? 1 : 0));
  endfunction

  function automatic logic [8:0] ref_ex(input logic [7:0] a, input logic [7:0] b);
    return 9'(int'(a) - int'(b));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model; inputs are stable here and describe the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_op_a = 0; m_err_a = 0; m_op_e = 0;
      hold_v = 1'b0;
      chk("rst_out_valid_a", out_valid_a, 0);
      chk("rst_out_valid_e", out_valid_e, 0);
      chk("rst_O_a", O_a, 0);
      chk("rst_err_a", err_a, 0);
      chk("rst_op_a", op_a, 0);
    end else begin
      chk("in_ready_a", in_ready_a, (q.size() < 2) || out_ready);
      chk("in_ready_e", in_ready_e, (q.size() < 2) || out_ready);
      chk("out_valid_e", out_valid_e, out_valid_a);
      if (hold_v) begin
        chk("stall_valid", out_valid_a, 1);
        chk("stall_O", O_a, hold_o);
      end
`ifdef SUB8_APPROX_ERRSTAT_EN
      chk("op_cnt_a", op_a, m_op_a);
      chk("err_cnt_a", err_a, m_err_a);
      chk("op_cnt_e", op_e, m_op_e);
      chk("err_cnt_e", err_e, 0);
`else
      chk("op_cnt_a_tied", op_a, 0);
      chk("err_cnt_a_tied", err_a, 0);
`endif
      hold_v = out_valid_a && !out_ready;
      hold_o = O_a;
      if (out_valid_a && out_ready) begin
        chk("result_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          pair_t p;
          int d;
          p = q.pop_front();
          chk("O_apx", O_a, ref_apx(p.a, p.b));
          chk("O_exact", O_e, ref_ex(p.a, p.b));
          d = int'($signed(O_a)) - int'($signed(O_e));
          chk("err_shape", 64'(d), (!p.a[0] && p.b[0]) ? 1 : 0);
          if (m_op_a < 131071) m_op_a++;
          if (m_op_e < 65535) m_op_e++;
          if (ref_apx(p.a, p.b) != ref_ex(p.a, p.b) && m_err_a < 131071) m_err_a++;
        end
      end
      if (in_valid && in_ready_a) q.push_back('{a: A, b: B});
    end
  end

  task automatic directed(input logic [7:0] a, input logic [7:0] b,
                          input logic [8:0] exp_a, input logic [8:0] exp_e,
                          input int cum_err, input int cum_op);
    int k;
    A = a; B = b; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 1;
    while (!out_valid_a && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    chk("latency", k, 2);
    chk("lit_O_apx", O_a, exp_a);
    chk("lit_O_exact", O_e, exp_e);
    @(posedge clk); #1;
`ifdef SUB8_APPROX_ERRSTAT_EN
    chk("lit_err_cnt", err_a, cum_err);
    chk("lit_op_cnt", op_a, cum_op);
`else
    chk("lit_cnt_tied", {err_a, op_a}, 0);
    if (cum_err < 0 || cum_op < 0) $display("bad directed table entry");
`endif
  endtask

  task automatic drain();
    int k = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    int  sent;
    bit  fell;
    bit  saw_valid;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_in_ready", in_ready_a, 1);
    chk("reset_out_valid", out_valid_a, 0);
    chk("reset_O", O_a, 0);

    directed(8'h10, 8'h01, 9'h010, 9'h00F, 1, 1);
    directed(8'h00, 8'hFF, 9'h102, 9'h101, 2, 2);
    directed(8'hFF, 8'h00, 9'h0FF, 9'h0FF, 2, 3);
    directed(8'h05, 8'h05, 9'h000, 9'h000, 2, 4);

    // Eight back-to-back operands with the consumer stalled in cycles 3..6.
    sent = 0;
    fell = 1'b0;
    for (int c = 0; c < 40 && sent < 8; c++) begin
      bit acc;
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = 1'b1;
      A = 8'($urandom_range(0, 255));
      B = 8'($urandom_range(0, 255));
      #3;
      acc = in_ready_a;
      if (!in_ready_a) fell = 1'b1;
      @(posedge clk); #1;
      if (acc) sent++;
    end
    chk("stream_sent", sent, 8);
    chk("stream_in_ready_fell", fell, 1);
    drain();

    // Randomized valid/ready traffic.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      A = 8'($urandom_range(0, 255));
      B = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
    end
    drain();

    // Reset with two results in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    A = 8'h3C; B = 8'h5A;
    @(posedge clk); #1;
    A = 8'h81; B = 8'h02;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("inflight_count", q.size(), 2);
    chk("inflight_valid", out_valid_a, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_drop_valid_a", out_valid_a, 0);
    chk("async_drop_valid_e", out_valid_e, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("post_reset_in_ready", in_ready_a, 1);
    out_ready = 1'b1;
    saw_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid_a || out_valid_e) saw_valid = 1'b1;
    end
    chk("no_stale_result", saw_valid, 0);

    // Exhaustive sweep of all operand pairs at full throughput from fresh counters.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      A = 8'(i >> 8);
      B = 8'(i);
      @(posedge clk); #1;
    end
    drain();
    @(posedge clk); #1;
`ifdef SUB8_APPROX_ERRSTAT_EN
    chk("sweep_err_cnt_apx", err_a, 16384);
    chk("sweep_op_cnt_apx", op_a, 65536);
    chk("sweep_op_cnt_exact_sat", op_e, 16'hFFFF);
    chk("sweep_err_cnt_exact", err_e, 0);
`else
    chk("sweep_cnt_tied", {err_a, op_a, err_e, op_e}, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
